// File: rtl/att_auto_ctrl_if.sv
// Control/status bundle between the host decoder, the ADC overflow pin and the
// attenuator driver for att_auto_ctrl.
interface att_auto_ctrl_if;
  logic [4:0] host_att;
  logic       auto_en;
  logic       adc_ovf;
  logic [7:0] att;
  logic [4:0] auto_add;
  logic       ovf_flag;
  logic       att_sat;

  modport master (
    output host_att,
    output auto_en,
    output adc_ovf,
    input  att,
    input  auto_add,
    input  ovf_flag,
    input  att_sat
  );

  modport slave (
    input  host_att,
    input  auto_en,
    input  adc_ovf,
    output att,
    output auto_add,
    output ovf_flag,
    output att_sat
  );
endinterface

// File: rtl/att_auto_ctrl.sv
// Attenuation code = host request + automatic overload term, with fast attack
// on sustained ADC overrange, holdoff for attenuator settling and slow release.
module att_auto_ctrl #(
  parameter int unsigned OVF_MIN      = 4,
  parameter int unsigned STEP         = 2,
  parameter int unsigned HOLD_CYCLES  = 4096,
  parameter int unsigned DECAY_CYCLES = 1228800
) (
  input  logic            clock,
  input  logic            reset,
  att_auto_ctrl_if.slave  bus
);

  localparam int unsigned RUN_W   = $clog2(OVF_MIN + 1);
  localparam int unsigned HOLD_W  = (HOLD_CYCLES  > 1) ? $clog2(HOLD_CYCLES)  : 1;
  localparam int unsigned DECAY_W = (DECAY_CYCLES > 1) ? $clog2(DECAY_CYCLES) : 1;
  localparam int unsigned ADD_W   = 5;
  localparam int unsigned SUM_W   = 6;

  localparam logic [0:0] ST_TRACK   = 1'b0;
  localparam logic [0:0] ST_HOLDOFF = 1'b1;

  logic [0:0]         state_q,     state_d;
  logic [RUN_W-1:0]   ovf_run_q,   ovf_run_d;
  logic [HOLD_W-1:0]  hold_cnt_q,  hold_cnt_d;
  logic [DECAY_W-1:0] decay_cnt_q, decay_cnt_d;
  logic [ADD_W-1:0]   auto_add_q,  auto_add_d;
  logic [ADD_W-1:0]   att_q,       att_d;
  logic               att_sat_q,   att_sat_d;
  logic               ovf_flag_q,  ovf_flag_d;

  logic [SUM_W-1:0]   sum;
  logic [SUM_W-1:0]   add_step;
  logic               qualified;

  // State register and all registered outputs.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= ST_TRACK;
      ovf_run_q   <= '0;
      hold_cnt_q  <= '0;
      decay_cnt_q <= '0;
      auto_add_q  <= '0;
      att_q       <= '0;
      att_sat_q   <= 1'b0;
      ovf_flag_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      ovf_run_q   <= ovf_run_d;
      hold_cnt_q  <= hold_cnt_d;
      decay_cnt_q <= decay_cnt_d;
      auto_add_q  <= auto_add_d;
      att_q       <= att_d;
      att_sat_q   <= att_sat_d;
      ovf_flag_q  <= ovf_flag_d;
    end
  end

  // Next-state, counters and output arithmetic.
  always_comb begin
    state_d     = state_q;
    hold_cnt_d  = hold_cnt_q;
    decay_cnt_d = decay_cnt_q;
    auto_add_d  = auto_add_q;
    sum         = SUM_W'(bus.host_att) + SUM_W'(auto_add_q);
    add_step    = SUM_W'(auto_add_q) + SUM_W'(STEP);

    // ovf_run only exceeds OVF_MIN-1 inside HOLDOFF, so >= lets a still-present
    // overload attack on the first TRACK cycle after the holdoff.
    qualified = bus.adc_ovf && (ovf_run_q >= RUN_W'(OVF_MIN - 1));

    if (!bus.adc_ovf) begin
      ovf_run_d = '0;
    end else if (ovf_run_q == RUN_W'(OVF_MIN)) begin
      ovf_run_d = ovf_run_q;
    end else begin
      ovf_run_d = ovf_run_q + RUN_W'(1);
    end

    case (state_q)
      ST_TRACK: begin
        if (qualified) begin
          auto_add_d  = (add_step > SUM_W'(31)) ? ADD_W'(31) : add_step[ADD_W-1:0];
          hold_cnt_d  = HOLD_W'(HOLD_CYCLES - 1);
          decay_cnt_d = '0;
          ovf_run_d   = '0;
          state_d     = ST_HOLDOFF;
        end else if (bus.adc_ovf) begin
          decay_cnt_d = '0;
        end else if (auto_add_q != '0) begin
          if (decay_cnt_q == DECAY_W'(DECAY_CYCLES - 1)) begin
            auto_add_d  = auto_add_q - ADD_W'(1);
            decay_cnt_d = '0;
          end else begin
            decay_cnt_d = decay_cnt_q + DECAY_W'(1);
          end
        end else begin
          decay_cnt_d = '0;
        end
      end
      ST_HOLDOFF: begin
        if (hold_cnt_q == '0) begin
          state_d = ST_TRACK;
        end else begin
          hold_cnt_d = hold_cnt_q - HOLD_W'(1);
        end
        if (bus.adc_ovf) begin
          decay_cnt_d = '0;
        end
      end
      default: begin
        state_d = ST_TRACK;
      end
    endcase

    // Disabling overrides every state action and bypasses the automatic term.
    if (!bus.auto_en) begin
      state_d     = ST_TRACK;
      ovf_run_d   = '0;
      hold_cnt_d  = '0;
      decay_cnt_d = '0;
      auto_add_d  = '0;
      sum         = SUM_W'(bus.host_att);
    end

    att_sat_d  = (sum > SUM_W'(31));
    att_d      = att_sat_d ? ADD_W'(31) : sum[ADD_W-1:0];
    ovf_flag_d = (state_d == ST_HOLDOFF);
  end

  assign bus.att      = {3'b000, att_q};
  assign bus.auto_add = auto_add_q;
  assign bus.ovf_flag = ovf_flag_q;
  assign bus.att_sat  = att_sat_q;

endmodule

// File: tb/tb_att_auto_ctrl.sv
// Directed plan scenarios plus a randomized phase, checked against an
// event-level model of the overload attack/holdoff/release behaviour.
module tb_att_auto_ctrl;
  localparam int OVF_MIN = 4;
  localparam int STEP    = 2;
  localparam int HOLD    = 16;
  localparam int DECAY   = 64;

  logic clock;
  logic reset;
  att_auto_ctrl_if bus ();

  att_auto_ctrl #(
    .OVF_MIN(OVF_MIN), .STEP(STEP), .HOLD_CYCLES(HOLD), .DECAY_CYCLES(DECAY)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  // Model state: consecutive overrange length, holdoff cycles left, quiet cycles.
  int m_run, m_hold, m_quiet, m_auto, m_att, m_sat, m_flag;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_step(input bit r, input bit en, input bit ovf, input int host);
    int s, n_run, n_hold, n_quiet, n_auto;
    if (r || !en) begin
      m_run = 0; m_hold = 0; m_quiet = 0; m_auto = 0; m_flag = 0; m_sat = 0;
      m_att = r ? 0 : host;
      return;
    end
    s       = host + m_auto;
    n_run   = ovf ? m_run + 1 : 0;
    n_hold  = m_hold;
    n_quiet = m_quiet;
    n_auto  = m_auto;
    if (m_hold == 0) begin
      if (ovf && (m_run + 1 >= OVF_MIN)) begin
        n_auto  = (m_auto + STEP > 31) ? 31 : m_auto + STEP;
        n_hold  = HOLD;
        n_quiet = 0;
        n_run   = 0;
      end else if (ovf) begin
        n_quiet = 0;
      end else if (m_auto != 0) begin
        n_quiet = m_quiet + 1;
        if (n_quiet == DECAY) begin
          n_auto  = m_auto - 1;
          n_quiet = 0;
        end
      end else begin
        n_quiet = 0;
      end
    end else begin
      n_hold = m_hold - 1;
      if (ovf) n_quiet = 0;
    end
    m_att   = (s > 31) ? 31 : s;
    m_sat   = (s > 31) ? 1 : 0;
    m_run   = n_run;
    m_hold  = n_hold;
    m_quiet = n_quiet;
    m_auto  = n_auto;
    m_flag  = (n_hold > 0) ? 1 : 0;
  endtask

  task automatic tick(input bit r, input bit en, input bit ovf, input int host);
    reset        = r;
    bus.auto_en  = en;
    bus.adc_ovf  = ovf;
    bus.host_att = 5'(host);
    @(posedge clock);
    model_step(r, en, ovf, host);
    #1;
    chk("att",      32'(bus.att),      32'(m_att));
    chk("auto_add", 32'(bus.auto_add), 32'(m_auto));
    chk("ovf_flag", 32'(bus.ovf_flag), 32'(m_flag));
    chk("att_sat",  32'(bus.att_sat),  32'(m_sat));
  endtask

  initial begin
    int flag_cnt, attacks, prev_auto, host;
    bit en, ovf, burst;

    reset = 1'b1; bus.auto_en = 1'b1; bus.adc_ovf = 1'b0; bus.host_att = 5'd10;
    m_run = 0; m_hold = 0; m_quiet = 0; m_auto = 0; m_att = 0; m_sat = 0; m_flag = 0;

    // 1: reset, then host value appears one cycle after release
    tick(1, 1, 0, 10);
    tick(1, 1, 0, 10);
    chk("rst_att", 32'(bus.att), 32'd0);
    tick(0, 1, 0, 10);
    chk("p1_att", 32'(bus.att), 32'd10);

    // 2: three-cycle overrange is ignored, four-cycle one attacks
    repeat (3) tick(0, 1, 1, 10);
    repeat (3) tick(0, 1, 0, 10);
    chk("p2_no_attack", 32'(bus.auto_add), 32'd0);
    repeat (4) tick(0, 1, 1, 10);
    flag_cnt = int'(bus.ovf_flag);
    tick(0, 1, 0, 10);
    chk("p2_att12", 32'(bus.att), 32'd12);
    flag_cnt += int'(bus.ovf_flag);
    repeat (19) begin
      tick(0, 1, 0, 10);
      flag_cnt += int'(bus.ovf_flag);
    end
    chk("p2_flag_len", 32'(flag_cnt), 32'd16);

    // 3: sustained overrange attacks once per holdoff window
    tick(0, 0, 0, 10);
    attacks = 0;
    repeat (40) begin
      prev_auto = int'(bus.auto_add);
      tick(0, 1, 1, 10);
      if (int'(bus.auto_add) > prev_auto) attacks++;
    end
    chk("p3_attacks", 32'(attacks), 32'd3);
    chk("p3_auto", 32'(bus.auto_add), 32'd6);
    tick(0, 1, 1, 10);
    chk("p3_att16", 32'(bus.att), 32'd16);

    // 4: slow release, single pulse restarts the decay count without attacking
    repeat (62) tick(0, 1, 0, 10);
    tick(0, 1, 1, 10);
    chk("p4_pulse_no_attack", 32'(bus.auto_add), 32'd6);
    repeat (440) tick(0, 1, 0, 10);
    chk("p4_released", 32'(bus.auto_add), 32'd0);

    // 5: clipping and saturation of the automatic term
    repeat (4) tick(0, 1, 1, 30);
    tick(0, 1, 0, 30);
    chk("p5_att_clip", 32'(bus.att), 32'd31);
    chk("p5_sat", 32'(bus.att_sat), 32'd1);
    repeat (320) tick(0, 1, 1, 30);
    chk("p5_auto_max", 32'(bus.auto_add), 32'd31);

    // 6: disable and reset in the middle of a holdoff
    tick(0, 0, 0, 7);
    repeat (4) tick(0, 1, 1, 7);
    repeat (5) tick(0, 1, 0, 7);
    chk("p6_in_hold", 32'(bus.ovf_flag), 32'd1);
    tick(0, 0, 0, 7);
    chk("p6_dis_auto", 32'(bus.auto_add), 32'd0);
    chk("p6_dis_att", 32'(bus.att), 32'd7);
    chk("p6_dis_flag", 32'(bus.ovf_flag), 32'd0);
    tick(0, 1, 0, 7);
    repeat (4) tick(0, 1, 1, 7);
    repeat (3) tick(0, 1, 0, 7);
    chk("p6_in_hold2", 32'(bus.ovf_flag), 32'd1);
    tick(1, 1, 0, 7);
    chk("p6_rst_att", 32'(bus.att), 32'd0);
    chk("p6_rst_auto", 32'(bus.auto_add), 32'd0);
    chk("p6_rst_flag", 32'(bus.ovf_flag), 32'd0);

    // Randomized bursty overrange with occasional host changes, disables, resets
    host  = 5;
    burst = 1'b0;
    repeat (4000) begin
      if ($urandom_range(0, 19) == 0) burst = ~burst;
      if ($urandom_range(0, 49) == 0) host = int'($urandom_range(0, 31));
      ovf = burst ? ($urandom_range(0, 9) != 0) : ($urandom_range(0, 29) == 0);
      en  = ($urandom_range(0, 499) != 0);
      tick(($urandom_range(0, 999) == 0), en, ovf, host);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
